// File: rtl/gate_chk_pkg.sv
// Shared encodings for the gate truth-table checker.
// Function select codes and FSM state encoding.
package gate_chk_pkg;

    localparam int FUNC_W = 3;

    localparam logic [FUNC_W-1:0] FUNC_AND  = 3'b000;
    localparam logic [FUNC_W-1:0] FUNC_OR   = 3'b001;
    localparam logic [FUNC_W-1:0] FUNC_XOR  = 3'b010;
    localparam logic [FUNC_W-1:0] FUNC_NAND = 3'b011;
    localparam logic [FUNC_W-1:0] FUNC_NOR  = 3'b100;
    localparam logic [FUNC_W-1:0] FUNC_XNOR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_CHECK  = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/gate_truth_checker_if.sv
// Checker <-> environment bundle: run control, gate a/b/y side, results.
// master is the checker, slave is whoever drives start/func and the gate.
interface gate_truth_checker_if
    import gate_chk_pkg::*;
#(
    parameter int N_IN = 2
);

    logic              start;
    logic [FUNC_W-1:0] func;
    logic [N_IN-1:0]   dut_in;
    logic              dut_y;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_fail_vec;

    modport master (
        input  start,
        input  func,
        input  dut_y,
        output dut_in,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_vec
    );

    modport slave (
        output start,
        output func,
        output dut_y,
        input  dut_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_vec
    );

endinterface

// File: rtl/gate_ref_model.sv
// Combinational reference: expected gate output for (func, vec).
// Reserved function codes expect a constant 0.
module gate_ref_model
    import gate_chk_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [FUNC_W-1:0] func_i,
    input  logic [N_IN-1:0]   vec_i,
    output logic              exp_o
);

    always_comb begin
        exp_o = 1'b0;
        unique case (func_i)
            FUNC_AND:  exp_o = &vec_i;
            FUNC_OR:   exp_o = |vec_i;
            FUNC_XOR:  exp_o = ^vec_i;
            FUNC_NAND: exp_o = ~&vec_i;
            FUNC_NOR:  exp_o = ~|vec_i;
            FUNC_XNOR: exp_o = ~^vec_i;
            default:   exp_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_truth_checker.sv
// Truth-table exerciser: walks every input vector, waits SETTLE cycles,
// samples the gate output and accumulates mismatches into pass/fail.
module gate_truth_checker
    import gate_chk_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input logic clk,
    input logic rst,
    gate_truth_checker_if.master bus
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_e            state_q, state_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              pass_q, pass_d;

    logic exp_y;
    logic mismatch;
    logic busy;
    logic done;

    gate_ref_model #(
        .N_IN(N_IN)
    ) u_ref (
        .func_i(func_q),
        .vec_i (vec_q),
        .exp_o (exp_y)
    );

    assign mismatch = (bus.dut_y != exp_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        func_d = func_q;
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        ffv_d  = ffv_q;
        pass_d = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    func_d = bus.func;
                    vec_d  = '0;
                    cnt_d  = CNT_INIT;
                    err_d  = '0;
                    ffv_d  = '0;
                    pass_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        ffv_d = vec_q;
                    end
                end
                // Verdict is registered on entry to DONE so it is valid with done.
                if (vec_q == VEC_LAST) begin
                    pass_d = (err_d == '0);
                end else begin
                    vec_d = vec_q + 1'b1;
                    cnt_d = CNT_INIT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            func_q <= '0;
            vec_q  <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
            ffv_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            func_q <= func_d;
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            ffv_q  <= ffv_d;
            pass_q <= pass_d;
        end
    end

    assign bus.dut_in         = vec_q;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (2-in/settle 2, 3-in/settle 1)
// checked every cycle against a run-timeline model plus directed literals.
module tb_gate_truth_checker;

    localparam int N0 = 2;
    localparam int S0 = 2;
    localparam int N1 = 3;
    localparam int S1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   gk0 = 1;
    int   gk1 = 2;

    int errors = 0;
    int checks = 0;

    gate_truth_checker_if #(.N_IN(N0)) if0 ();
    gate_truth_checker_if #(.N_IN(N1)) if1 ();

    gate_truth_checker #(.N_IN(N0), .SETTLE(S0)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(if0)
    );

    gate_truth_checker #(.N_IN(N1), .SETTLE(S1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(if1)
    );

    always #5 clk = ~clk;

    function automatic int popc(input int v);
        int c;
        c = 0;
        for (int i = 0; i < 16; i++) begin
            c += (v >> i) & 1;
        end
        return c;
    endfunction

    function automatic bit fexp(input int f, input int v, input int n);
        int all;
        all = (1 << n) - 1;
        case (f)
            0: return v == all;
            1: return v != 0;
            2: return (popc(v) % 2) == 1;
            3: return v != all;
            4: return v == 0;
            5: return (popc(v) % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Gates under test sit on the other side of the a/b/y interface.
    assign if0.dut_y = fexp(gk0, int'(if0.dut_in), N0);
    assign if1.dut_y = fexp(gk1, int'(if1.dut_in), N1);

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
        end
    endtask

    function automatic int nin(input int u);
        return (u == 0) ? N0 : N1;
    endfunction

    function automatic int stl(input int u);
        return (u == 0) ? S0 : S1;
    endfunction

    function automatic bit gate_y(input int u, input int v);
        return fexp((u == 0) ? gk0 : gk1, v, nin(u));
    endfunction

    // Model: a run is a timeline of m edges since the accepting edge.
    bit act[2];
    int m[2];
    int mf[2];
    int h_err[2];
    int h_ffv[2];
    int h_vec[2];
    int h_pass[2];

    function automatic void model_out(
        input  int u,
        output int busy,
        output int done,
        output int pass,
        output int vec,
        output int err,
        output int ffv
    );
        int nv_all;
        int p;
        int nv;
        nv_all = 1 << nin(u);
        p = stl(u) + 1;
        if (!act[u]) begin
            busy = 0;
            done = 0;
            pass = h_pass[u];
            vec  = h_vec[u];
            err  = h_err[u];
            ffv  = h_ffv[u];
        end else begin
            busy = 1;
            done = (m[u] == nv_all * p) ? 1 : 0;
            nv   = (done == 1) ? nv_all : m[u] / p;
            vec  = (done == 1) ? nv_all - 1 : m[u] / p;
            err  = 0;
            ffv  = 0;
            for (int v = 0; v < nv; v++) begin
                if (gate_y(u, v) != fexp(mf[u], v, nin(u))) begin
                    if (err == 0) ffv = v;
                    err++;
                end
            end
            pass = (done == 1 && err == 0) ? 1 : 0;
        end
    endfunction

    task automatic model_step(input int u, input bit r, input bit s,
                              input int f);
        int b, d, p, v, e, ff;
        if (r) begin
            act[u] = 1'b0;
            h_err[u] = 0;
            h_ffv[u] = 0;
            h_vec[u] = 0;
            h_pass[u] = 0;
        end else if (!act[u]) begin
            if (s) begin
                act[u] = 1'b1;
                m[u] = 0;
                mf[u] = f;
            end
        end else if (m[u] == (1 << nin(u)) * (stl(u) + 1)) begin
            model_out(u, b, d, p, v, e, ff);
            h_err[u] = e;
            h_ffv[u] = ff;
            h_vec[u] = v;
            h_pass[u] = p;
            act[u] = 1'b0;
        end else begin
            m[u]++;
        end
    endtask

    function automatic int busy_of(input int u);
        return (u == 0) ? int'(if0.busy) : int'(if1.busy);
    endfunction

    function automatic int done_of(input int u);
        return (u == 0) ? int'(if0.done) : int'(if1.done);
    endfunction

    function automatic int pass_of(input int u);
        return (u == 0) ? int'(if0.pass) : int'(if1.pass);
    endfunction

    function automatic int vec_of(input int u);
        return (u == 0) ? int'(if0.dut_in) : int'(if1.dut_in);
    endfunction

    function automatic int err_of(input int u);
        return (u == 0) ? int'(if0.err_count) : int'(if1.err_count);
    endfunction

    function automatic int ffv_of(input int u);
        return (u == 0) ? int'(if0.first_fail_vec) : int'(if1.first_fail_vec);
    endfunction

    // Compare process: inputs captured at the edge, outputs checked mid-cycle.
    initial begin
        bit r;
        bit st[2];
        int fn[2];
        int b, d, p, v, e, ff;
        forever begin
            @(posedge clk);
            r = rst;
            st[0] = if0.start;
            st[1] = if1.start;
            fn[0] = int'(if0.func);
            fn[1] = int'(if1.func);
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                model_step(u, r, st[u], fn[u]);
                model_out(u, b, d, p, v, e, ff);
                chk($sformatf("u%0d_busy", u), busy_of(u), b);
                chk($sformatf("u%0d_done", u), done_of(u), d);
                chk($sformatf("u%0d_pass", u), pass_of(u), p);
                chk($sformatf("u%0d_dut_in", u), vec_of(u), v);
                chk($sformatf("u%0d_err_count", u), err_of(u), e);
                chk($sformatf("u%0d_first_fail", u), ffv_of(u), ff);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int u, input bit b);
        if (u == 0) if0.start = b;
        else if1.start = b;
    endtask

    task automatic set_func(input int u, input int f);
        if (u == 0) if0.func = 3'(f);
        else if1.func = 3'(f);
    endtask

    int seq[$];

    // lat1/lat2: edges after the accepting edge at which done is seen.
    task automatic run(input int u, input int f, input bit hold,
                       input bit poke, output int lat1, output int lat2,
                       output int nd);
        int want;
        lat1 = -1;
        lat2 = -1;
        nd = 0;
        want = hold ? 2 : 1;
        seq.delete();
        set_func(u, f);
        set_start(u, 1'b1);
        tick();
        for (int k = 0; k < 300; k++) begin
            if (!hold) set_start(u, 1'b0);
            if (poke && k == 4) begin
                set_start(u, 1'b1);
                set_func(u, 4);
            end
            if (busy_of(u) == 1 &&
                (seq.size() == 0 || seq[$] != vec_of(u))) begin
                seq.push_back(vec_of(u));
            end
            if (done_of(u) == 1) begin
                nd++;
                if (lat1 < 0) lat1 = k;
                else lat2 = k;
                if (nd == want) set_start(u, 1'b0);
            end
            if (nd >= want && done_of(u) == 0) break;
            tick();
        end
        for (int j = 0; j < 10; j++) begin
            tick();
            if (done_of(u) == 1) nd++;
        end
    endtask

    initial begin
        int l1, l2, nd;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if0.func = 3'd0;
        if1.func = 3'd0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", busy_of(0), 0);
        chk("reset_pass", pass_of(0), 0);
        chk("reset_err", err_of(1), 0);

        // Correct OR gate, OR expected: done during cycle t+13.
        run(0, 1, 1'b0, 1'b0, l1, l2, nd);
        chk("or_done_latency", l1, 12);
        chk("or_done_pulses", nd, 1);
        chk("or_seq_len", seq.size(), 4);
        for (int i = 0; i < 4 && i < seq.size(); i++) begin
            chk($sformatf("or_seq_%0d", i), seq[i], i);
        end
        chk("or_pass", pass_of(0), 1);
        chk("or_err", err_of(0), 0);
        chk("or_ffv", ffv_of(0), 0);

        run(0, 0, 1'b0, 1'b0, l1, l2, nd);
        chk("and_err", err_of(0), 2);
        chk("and_ffv", ffv_of(0), 1);
        chk("and_pass", pass_of(0), 0);

        run(0, 4, 1'b0, 1'b0, l1, l2, nd);
        chk("nor_err", err_of(0), 4);
        chk("nor_ffv", ffv_of(0), 0);
        chk("nor_pass", pass_of(0), 0);

        run(0, 6, 1'b0, 1'b0, l1, l2, nd);
        chk("rsvd_err", err_of(0), 3);
        chk("rsvd_ffv", ffv_of(0), 1);

        // Abort during SETTLE of vector 2.
        set_func(0, 4);
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        for (int k = 0; k < 50 && vec_of(0) != 2; k++) tick();
        chk("abort_at_vec2", vec_of(0), 2);
        chk("abort_err_before", err_of(0), 2);
        rst = 1'b1;
        tick();
        chk("abort_busy", busy_of(0), 0);
        chk("abort_done", done_of(0), 0);
        chk("abort_dut_in", vec_of(0), 0);
        chk("abort_err", err_of(0), 0);
        chk("abort_ffv", ffv_of(0), 0);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done_of(0) == 1) nd++;
        end
        chk("abort_no_done", nd, 0);

        // start re-pulsed while busy, func changed mid-run.
        run(0, 1, 1'b0, 1'b1, l1, l2, nd);
        chk("poke_done_pulses", nd, 1);
        chk("poke_latency", l1, 12);
        chk("poke_pass", pass_of(0), 1);
        chk("poke_err", err_of(0), 0);

        // 3-input XOR, start held: back-to-back runs 18 cycles apart.
        run(1, 2, 1'b1, 1'b0, l1, l2, nd);
        chk("xor_done_latency", l1, 16);
        chk("xor_b2b_gap", l2 - l1, 18);
        chk("xor_done_pulses", nd, 2);
        chk("xor_pass", pass_of(1), 1);
        chk("xor_err", err_of(1), 0);

        gk1 = 1;
        tick();
        run(1, 2, 1'b0, 1'b0, l1, l2, nd);
        chk("xor_vs_or_err", err_of(1), 3);
        chk("xor_vs_or_ffv", ffv_of(1), 3);
        chk("xor_vs_or_pass", pass_of(1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
